// File: rtl/fp_pkg.sv
// Shared types and constants for the fixed-point multiplier dot-product sequencer.
package fp_pkg;

   typedef enum logic [1:0] {SEQ_IDLE, SEQ_MUL, SEQ_OUT} seq_state_t;

   // Cycles from the first go-high cycle to the done cycle of the attached multiplier.
   localparam int unsigned MULT_PIPE_LATENCY = 3;

endpackage

// File: rtl/fp_acc_sat_cnt.sv
// Dot-product accumulator: extends each product to the accumulator width, adds it
// with wrap detection, and counts accumulated elements with saturation.
module fp_acc_sat_cnt #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_WIDTH = 48,
   parameter int unsigned CNT_WIDTH = 16,
   parameter bit          SIGNED    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 en,
   input  logic [WIDTH-1:0]     prod,
   output logic [ACC_WIDTH-1:0] acc,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 ovf
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic [ACC_WIDTH-1:0] ext_c;
   logic [ACC_WIDTH:0]   sum_c;
   logic                 wrap_c;

   if (SIGNED) begin : g_sext
      assign ext_c = ACC_WIDTH'($signed(prod));
   end else begin : g_zext
      assign ext_c = ACC_WIDTH'(prod);
   end

   // Unsigned wrap is the carry-out; signed wrap is same-sign operands giving an opposite-sign sum.
   always_comb begin
      sum_c = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(ext_c);
      if (SIGNED) begin
         wrap_c = (acc_q[ACC_WIDTH-1] == ext_c[ACC_WIDTH-1]) &&
                  (sum_c[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      end else begin
         wrap_c = sum_c[ACC_WIDTH];
      end
   end

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (en) begin
         acc_d = sum_c[ACC_WIDTH-1:0];
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
         ovf_d = ovf_q | wrap_c;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign acc = acc_q;
   assign cnt = cnt_q;
   assign ovf = ovf_q;

endmodule

// File: rtl/fp_mult_dot_seq.sv
// Dot-product sequencer: feeds operand pairs to an external pipelined multiplier via
// go/done, accumulates the products and emits the sum and count on the 'last' pair.
module fp_mult_dot_seq
   import fp_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned ACC_WIDTH = 48,
   parameter int unsigned CNT_WIDTH = 16,
   parameter bit          SIGNED    = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_last,
   output logic [WIDTH-1:0]     mul_left,
   output logic [WIDTH-1:0]     mul_right,
   output logic                 mul_go,
   input  logic [WIDTH-1:0]     mul_out,
   input  logic                 mul_done,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ACC_WIDTH-1:0] res_data,
   output logic [CNT_WIDTH-1:0] res_count,
   output logic                 res_ovf
);

   seq_state_t           state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 last_q, last_d;
   logic                 acc_en_c;
   logic                 acc_clr_c;
   logic [ACC_WIDTH-1:0] acc_w;
   logic [CNT_WIDTH-1:0] cnt_w;
   logic                 ovf_w;

   // Leaving MUL on done always passes through IDLE or OUT, so go drops for at least one cycle.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      last_d    = last_q;
      acc_en_c  = 1'b0;
      acc_clr_c = 1'b0;
      unique case (state_q)
         SEQ_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               last_d  = in_last;
               state_d = SEQ_MUL;
            end
         end
         SEQ_MUL: begin
            if (mul_done) begin
               acc_en_c = 1'b1;
               state_d  = last_q ? SEQ_OUT : SEQ_IDLE;
            end
         end
         SEQ_OUT: begin
            if (res_ready) begin
               acc_clr_c = 1'b1;
               state_d   = SEQ_IDLE;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEQ_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         last_q  <= last_d;
      end
   end

   fp_acc_sat_cnt #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .SIGNED    (SIGNED)
   ) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr_c),
      .en    (acc_en_c),
      .prod  (mul_out),
      .acc   (acc_w),
      .cnt   (cnt_w),
      .ovf   (ovf_w)
   );

   // Every output reads as zero while reset is held, whatever the registers still contain.
   assign in_ready  = (state_q == SEQ_IDLE) & ~reset;
   assign mul_go    = (state_q == SEQ_MUL)  & ~reset;
   assign res_valid = (state_q == SEQ_OUT)  & ~reset;
   assign mul_left  = reset ? '0 : a_q;
   assign mul_right = reset ? '0 : b_q;
   assign res_data  = reset ? '0 : acc_w;
   assign res_count = reset ? '0 : cnt_w;
   assign res_ovf   = reset ? 1'b0 : ovf_w;

endmodule

// File: tb/tb_fp_mult_dot_seq.sv
// Bench for fp_mult_dot_seq: three variants (48b unsigned, 32b unsigned, 48b signed)
// share one stimulus stream, each with its own multiplier model, checked against a timeline model.
module tb_fp_mult_dot_seq;
   import fp_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned ND = 3;

   logic clk = 1'b0;
   logic reset, in_valid, in_last, res_ready;
   logic [W-1:0] in_a, in_b;

   logic [ND-1:0]           in_ready_w, mul_go_w, mul_done_w, res_valid_w, res_ovf_w;
   logic [ND-1:0][W-1:0]    mul_l_w, mul_r_w, mul_out_w;
   logic [ND-1:0][47:0]     res_data_w;
   logic [ND-1:0][CW-1:0]   res_count_w;
   logic [47:0]             res_data0, res_data2;
   logic [31:0]             res_data1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fp_mult_dot_seq #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(16), .SIGNED(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_left(mul_l_w[0]), .mul_right(mul_r_w[0]), .mul_go(mul_go_w[0]),
      .mul_out(mul_out_w[0]), .mul_done(mul_done_w[0]),
      .res_valid(res_valid_w[0]), .res_ready(res_ready), .res_data(res_data0),
      .res_count(res_count_w[0]), .res_ovf(res_ovf_w[0]));

   fp_mult_dot_seq #(.WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(16), .SIGNED(1'b0)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_left(mul_l_w[1]), .mul_right(mul_r_w[1]), .mul_go(mul_go_w[1]),
      .mul_out(mul_out_w[1]), .mul_done(mul_done_w[1]),
      .res_valid(res_valid_w[1]), .res_ready(res_ready), .res_data(res_data1),
      .res_count(res_count_w[1]), .res_ovf(res_ovf_w[1]));

   fp_mult_dot_seq #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(16), .SIGNED(1'b1)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_left(mul_l_w[2]), .mul_right(mul_r_w[2]), .mul_go(mul_go_w[2]),
      .mul_out(mul_out_w[2]), .mul_done(mul_done_w[2]),
      .res_valid(res_valid_w[2]), .res_ready(res_ready), .res_data(res_data2),
      .res_count(res_count_w[2]), .res_ovf(res_ovf_w[2]));

   assign res_data_w[0] = res_data0;
   assign res_data_w[1] = 48'(res_data1);
   assign res_data_w[2] = res_data2;

   // Multiplier model: done on the (LATENCY+1)th consecutive go cycle, re-arms after done, go low flushes.
   logic [ND-1:0][1:0] mcnt_q;
   always @(posedge clk) begin
      for (int i = 0; i < int'(ND); i++) begin
         if (!mul_go_w[i] || mul_done_w[i]) mcnt_q[i] <= 2'd0;
         else                                mcnt_q[i] <= mcnt_q[i] + 2'd1;
      end
   end
   for (genvar g = 0; g < int'(ND); g++) begin : g_mul
      assign mul_done_w[g] = mul_go_w[g] && (int'(mcnt_q[g]) == int'(MULT_PIPE_LATENCY));
      assign mul_out_w[g]  = mul_l_w[g] * mul_r_w[g];
   end

   task automatic chk(input string name, input int idx, input longint unsigned act,
                      input longint unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got 0x%0h expected 0x%0h", name, idx, $time, act, exp);
      end
   endtask

   function automatic int acc_w(input int i);
      return (i == 1) ? 32 : 48;
   endfunction

   // Timeline model: ph counts cycles since accept (0 idle, 1..4 multiply, 5 result waiting).
   int                ph = 0;
   logic [W-1:0]      m_a = '0, m_b = '0;
   bit                m_last = 1'b0;
   longint unsigned   m_acc [ND];
   bit                m_ovf [ND];
   int                m_cnt = 0;
   bit [ND-1:0]       prev_done = '0;
   int                go_cnt0 = 0;

   initial begin
      for (int i = 0; i < int'(ND); i++) begin
         m_acc[i] = 0;
         m_ovf[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      bit r;
      r = (reset === 1'b1);
      for (int i = 0; i < int'(ND); i++) begin
         chk("in_ready",  i, 64'(in_ready_w[i]),  64'(!r && ph == 0));
         chk("mul_go",    i, 64'(mul_go_w[i]),    64'(!r && ph >= 1 && ph <= 4));
         chk("res_valid", i, 64'(res_valid_w[i]), 64'(!r && ph == 5));
         chk("res_data",  i, 64'(res_data_w[i]),  r ? 64'd0 : m_acc[i]);
         chk("res_count", i, 64'(res_count_w[i]), r ? 64'd0 : 64'(m_cnt));
         chk("res_ovf",   i, 64'(res_ovf_w[i]),   r ? 64'd0 : 64'(m_ovf[i]));
         if (!r && ph >= 1 && ph <= 4) begin
            chk("mul_left",  i, 64'(mul_l_w[i]), 64'(m_a));
            chk("mul_right", i, 64'(mul_r_w[i]), 64'(m_b));
         end
         if (prev_done[i]) chk("go_after_done", i, 64'(mul_go_w[i]), 64'd0);
         prev_done[i] = mul_done_w[i];
      end
      if (mul_go_w[0]) go_cnt0++;

      if (r) begin
         ph = 0; m_a = '0; m_b = '0; m_last = 1'b0; m_cnt = 0;
         for (int i = 0; i < int'(ND); i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
      end else if (ph == 0) begin
         if (in_valid) begin ph = 1; m_a = in_a; m_b = in_b; m_last = in_last; end
      end else if (ph < 4) begin
         ph++;
      end else if (ph == 4) begin
         for (int i = 0; i < int'(ND); i++) begin
            longint unsigned p, mask, ext, sum;
            int w;
            w    = acc_w(i);
            mask = (64'd1 << w) - 64'd1;
            p    = (64'(m_a) * 64'(m_b)) & 64'hFFFF_FFFF;
            ext  = p;
            if (i == 2 && p[31]) ext = p | (mask & ~64'hFFFF_FFFF);
            sum  = m_acc[i] + ext;
            if (i == 2) begin
               if ((m_acc[i][w-1] == ext[w-1]) && (sum[w-1] != m_acc[i][w-1])) m_ovf[i] = 1'b1;
            end else if (sum[w]) begin
               m_ovf[i] = 1'b1;
            end
            m_acc[i] = sum & mask;
         end
         if (m_cnt < 65535) m_cnt++;
         ph = m_last ? 5 : 0;
      end else if (res_ready) begin
         ph = 0; m_cnt = 0;
         for (int i = 0; i < int'(ND); i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
      int n = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      do begin @(negedge clk); n++; end while (!in_ready_w[0] && n < 50);
      if (!in_ready_w[0]) chk("accept_timeout", 0, 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin @(negedge clk); n++; end while (!res_valid_w[0] && n < 50);
      if (!res_valid_w[0]) chk("result_timeout", 0, 64'd0, 64'd1);
   endtask

   task automatic lit(input string name, input int idx, input longint unsigned data,
                      input int cnt, input bit ovf);
      chk({name, "_data"},  idx, 64'(res_data_w[idx]),  data);
      chk({name, "_count"}, idx, 64'(res_count_w[idx]), 64'(cnt));
      chk({name, "_ovf"},   idx, 64'(res_ovf_w[idx]),   64'(ovf));
   endtask

   task automatic ack();
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
   endtask

   initial begin
      int g0;
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", 0, 64'(in_ready_w[0]), 64'd1);
      @(posedge clk); #1;

      // Three-element vector, four go cycles per pair
      g0 = go_cnt0;
      send(32'd3, 32'd4, 1'b0);
      send(32'd5, 32'd6, 1'b0);
      send(32'd7, 32'd8, 1'b1);
      wait_valid();
      lit("s1", 0, 64'd98, 3, 1'b0);
      lit("s1", 2, 64'd98, 3, 1'b0);
      chk("s1_go_cycles", 0, 64'(go_cnt0 - g0), 64'd12);
      ack();

      // Single element; product truncated to 32 bits
      send(32'hFFFF_FFFF, 32'd2, 1'b1);
      wait_valid();
      lit("s2", 0, 64'hFFFF_FFFE, 1, 1'b0);
      lit("s2", 2, 64'hFFFF_FFFF_FFFE, 1, 1'b0);
      ack();

      // Accumulator wrap on the 32-bit variant
      send(32'h8000_0000, 32'd1, 1'b0);
      send(32'h8000_0000, 32'd1, 1'b1);
      wait_valid();
      lit("s3", 1, 64'd0, 2, 1'b1);
      lit("s3", 0, 64'h1_0000_0000, 2, 1'b0);
      ack();

      // Backpressure with the next pair already offered
      send(32'd10, 32'd10, 1'b0);
      chk("s4_ovf_cleared", 1, 64'(res_ovf_w[1]), 64'd0);
      send(32'd1, 32'd1, 1'b1);
      wait_valid();
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9; in_last = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("s4_bp_ready", 0, 64'(in_ready_w[0]), 64'd0);
         lit("s4_bp", 1, 64'd101, 2, 1'b0);
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      chk("s4_ready_after_ack", 0, 64'(in_ready_w[0]), 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_valid();
      lit("s4_next", 0, 64'd81, 1, 1'b0);
      ack();

      // Reset in the second multiply cycle
      send(32'd5, 32'd5, 1'b1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("s5_go_in_reset", 0, 64'(mul_go_w[0]), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("s5_go_after", 0, 64'(mul_go_w[0]), 64'd0);
      chk("s5_ready_after", 0, 64'(in_ready_w[0]), 64'd1);
      @(posedge clk); #1;
      send(32'd2, 32'd3, 1'b1);
      wait_valid();
      lit("s5", 0, 64'd6, 1, 1'b0);
      ack();

      // Signed accumulation of (-2*3)+(4*1)
      send(32'hFFFF_FFFE, 32'd3, 1'b0);
      send(32'd4, 32'd1, 1'b1);
      wait_valid();
      lit("s6", 2, 64'hFFFF_FFFF_FFFE, 2, 1'b0);
      lit("s6", 0, 64'hFFFF_FFFE, 2, 1'b0);
      ack();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
